// File: rtl/dual_port_ram_tdp.sv
// True dual-port RAM with byte enables, per-word valid bitmap (fast logical clear),
// selectable cross-port read-during-write, optional output register and collision counter.
module dual_port_ram_tdp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 6,
    parameter int RDW_MODE = 0,
    parameter int OUT_REG  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en_a,
    input  logic                we_a,
    input  logic [ADDR_W-1:0]   addr_a,
    input  logic [DATA_W/8-1:0] be_a,
    input  logic [DATA_W-1:0]   wdata_a,
    output logic [DATA_W-1:0]   rdata_a,
    output logic                rvalid_a,
    input  logic                en_b,
    input  logic                we_b,
    input  logic [ADDR_W-1:0]   addr_b,
    input  logic [DATA_W/8-1:0] be_b,
    input  logic [DATA_W-1:0]   wdata_b,
    output logic [DATA_W-1:0]   rdata_b,
    output logic                rvalid_b,
    output logic                coll,
    output logic [15:0]         coll_cnt
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  vld;

    logic              wr_a, wr_b, rd_a, rd_b, coll_now;
    logic [DATA_W-1:0] old_a, old_b, new_a, new_b, rd_word_a, rd_word_b;
    logic              s1_rv_a, s1_rv_b;
    logic [DATA_W-1:0] s1_rd_a, s1_rd_b;

    always_comb begin
        wr_a     = en_a & we_a;
        rd_a     = en_a & ~we_a;
        rd_b     = en_b & ~we_b;
        coll_now = wr_a & en_b & we_b & (addr_a == addr_b);
        // Port A owns the whole word on a collision; B's write is dropped.
        wr_b     = en_b & we_b & ~coll_now;
        old_a    = vld[addr_a] ? mem[addr_a] : '0;
        old_b    = vld[addr_b] ? mem[addr_b] : '0;
        new_a    = old_a;
        new_b    = old_b;
        for (int k = 0; k < NB; k++) begin
            if (be_a[k]) new_a[8*k +: 8] = wdata_a[8*k +: 8];
            if (be_b[k]) new_b[8*k +: 8] = wdata_b[8*k +: 8];
        end
        rd_word_a = old_a;
        rd_word_b = old_b;
        if (RDW_MODE != 0 && wr_b && addr_b == addr_a) rd_word_a = new_b;
        if (RDW_MODE != 0 && wr_a && addr_a == addr_b) rd_word_b = new_a;
    end

    // Array has no reset; stale contents are masked by the valid bitmap.
    always_ff @(posedge clk) begin
        if (wr_a) mem[addr_a] <= new_a;
        if (wr_b) mem[addr_b] <= new_b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
        end else begin
            if (wr_a) vld[addr_a] <= 1'b1;
            if (wr_b) vld[addr_b] <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_rv_a <= 1'b0;
            s1_rv_b <= 1'b0;
            s1_rd_a <= '0;
            s1_rd_b <= '0;
        end else begin
            s1_rv_a <= rd_a;
            s1_rv_b <= rd_b;
            if (rd_a) s1_rd_a <= rd_word_a;
            if (rd_b) s1_rd_b <= rd_word_b;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              o_rv_a, o_rv_b;
            logic [DATA_W-1:0] o_rd_a, o_rd_b;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    o_rv_a <= 1'b0;
                    o_rv_b <= 1'b0;
                    o_rd_a <= '0;
                    o_rd_b <= '0;
                end else begin
                    o_rv_a <= s1_rv_a;
                    o_rv_b <= s1_rv_b;
                    if (s1_rv_a) o_rd_a <= s1_rd_a;
                    if (s1_rv_b) o_rd_b <= s1_rd_b;
                end
            end
            assign rdata_a  = o_rd_a;
            assign rdata_b  = o_rd_b;
            assign rvalid_a = o_rv_a;
            assign rvalid_b = o_rv_b;
        end else begin : g_no_out_reg
            assign rdata_a  = s1_rd_a;
            assign rdata_b  = s1_rd_b;
            assign rvalid_a = s1_rv_a;
            assign rvalid_b = s1_rv_b;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coll     <= 1'b0;
            coll_cnt <= '0;
        end else begin
            coll <= coll_now;
            if (coll_now && coll_cnt != 16'hFFFF) coll_cnt <= coll_cnt + 16'd1;
        end
    end

endmodule

// File: doc/dual_port_ram_tdp.md
Name: dual_port_ram_tdp

Overview:
- Parametrised true dual-port RAM: two symmetric ports, each able to read or write every cycle, with byte enables.
- Adds configurable read-during-write behaviour, an optional output pipeline stage, write-write collision detection and fast logical clear on reset.
- Serves as the general storage primitive for FIFOs, line buffers and register files in the design; replaces the fixed 16x8 write-A/read-B RAM.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 6, address width; DEPTH = 2**ADDR_W words.
- RDW_MODE, 0, cross-port same-address read-during-write: 0 = read-first (old data), 1 = write-first (new merged data).
- OUT_REG, 0, 0 = read latency 1 cycle; 1 = extra output register, read latency 2 cycles.

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- en_a  in  1  port A access enable
- we_a  in  1  port A write (1) / read (0); ignored when en_a=0
- addr_a  in  ADDR_W  port A word address
- be_a  in  DATA_W/8  port A byte enables (writes only; bit i covers byte i)
- wdata_a  in  DATA_W  port A write data
- rdata_a  out  DATA_W  port A read data
- rvalid_a  out  1  port A read data valid, one-cycle pulse per read
- en_b, we_b, addr_b, be_b, wdata_b, rdata_b, rvalid_b  as port A, for port B
- coll  out  1  pulses one cycle after a same-address write-write collision
- coll_cnt  out  16  saturating count of collisions since reset

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - rdata_a/b=0, rvalid_a/b=0, coll=0, coll_cnt=0.
  - Output pipeline flushed; reads in flight are discarded and produce no rvalid.
  - Per-word valid bitmap (DEPTH bits) cleared; memory array itself is not cleared.
- A read of a word whose valid bit is 0 returns all zeros.
- Write (en&we), applied at the clock edge:
  - Only bytes with be=1 are updated.
  - If the word is not yet valid, bytes with be=0 are written as 0.
  - The word's valid bit is set; be=0 on all bytes still sets valid (word becomes all-zero).
- Read (en&!we):
  - OUT_REG=0: rdata and rvalid update at the edge after the request.
  - OUT_REG=1: they update one edge later.
  - rvalid is high for exactly one cycle per read; rdata holds its last value when rvalid=0.
- Write cycle on a port: that port's rvalid is not asserted; its rdata is unchanged.
- Back-to-back reads on every cycle are supported; full throughput on both ports simultaneously.
- Cross-port, same address, same cycle:
  - Read/read: both ports return the same data.
  - Write on one port, read on the other:
    - RDW_MODE=0: reader gets the pre-write word (zeros if the word was invalid).
    - RDW_MODE=1: reader gets the post-write merged word.
  - Write/write: port A wins for the whole word; port B's write is dropped entirely (no byte merging). coll=1 on the following cycle and coll_cnt increments, saturating at 16'hFFFF.
- Different addresses: the two ports are fully independent.
- Writes or reads with en=0 have no effect; all address values 0..DEPTH-1 are legal, with no wrap or out-of-range case.

Test Plan:
- Reset, then read addr 5 on A with DATA_W=32, OUT_REG=0 -> rdata_a=0 and rvalid_a=1 one cycle later, although the array holds an arbitrary value.
- A writes 0xDEADBEEF at addr 3 with be=4'b0101 (fresh after reset), then B reads addr 3 -> rdata_b=0x00AD00EF. Then A writes 0x11223344 with be=4'b1000, B reads -> 0x11AD00EF.
- Same cycle: A writes 0xAAAA5555 to addr 7 (previously 0x12345678), B reads addr 7 -> RDW_MODE=0 gives 0x12345678, RDW_MODE=1 gives 0xAAAA5555. The following read gives 0xAAAA5555 in both modes.
- Same cycle: A writes 0x1 and B writes 0x2, both to addr 9 -> next cycle coll=1 and coll_cnt=1; later read returns 0x1. Repeat 3 times -> coll_cnt=4.
- OUT_REG=1: reads on A at addrs 0,1,2 on consecutive cycles -> rvalid_a high on cycles 2,3,4 with data in order. Assert rst between cycles 2 and 3 -> rvalid_a drops immediately and no further pulses appear.
- Full fill: write addr i with i on both ports (A even, B odd addresses) for all DEPTH=64 -> read back all 64 on both ports, all correct, coll never asserted.
